float8_div_seq: RTL and testbench

- Sequential divider for the team's 8-bit float format: sign a[7], exponent a[6:3], mantissa a[2:0], bias 7, implicit leading 1.
- Inverse operation of the combinational float8 multiplier.
- Computes a/b with a restoring mantissa division, one quotient bit per cycle.
- Sits behind a valid/ready handshake on both input and output so it can be stalled by the consumer.

---
 rtl/float8_div_seq.sv | 107 ++++++++++
 tb/tb_float8_div_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/float8_div_seq.sv
// Sequential float8 divider: restoring mantissa division, one quotient bit per cycle.
// Valid/ready on both sides. Only one operation can be in flight at a time.
module float8_div_seq #(
  parameter int BIAS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       div_by_zero,
  output logic       exp_err
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t      state, state_nxt;
  logic        sgn;
  logic [3:0]  ea, eb, d;
  logic [4:0]  r, q, r_sub;
  logic [2:0]  cnt;
  logic        accept, a_zero, b_zero, r_ge_d;
  logic [5:0]  e;
  logic [2:0]  man;

  assign a_zero = (a[6:0] == 7'd0);
  assign b_zero = (b[6:0] == 7'd0);
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (accept) state_nxt = (a_zero | b_zero) ? DONE : DIVIDE;
      DIVIDE:  if (cnt == 3'd4) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring step. After a subtract the remainder is below D, so the shift never drops a set bit.
  assign r_ge_d = (r >= {1'b0, d});
  assign r_sub  = r_ge_d ? (r - {1'b0, d}) : r;

  // e is read as a signed 6-bit value. Its range is -9..22, so bit 5 flags e<0 and bit 4 flags e>15.
  assign e   = {2'b00, ea} - {2'b00, eb} + 6'(BIAS) - {5'd0, ~q[4]};
  assign man = q[4] ? q[3:1] : q[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn         <= 1'b0;
      ea          <= '0;
      eb          <= '0;
      d           <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      result      <= 8'h00;
      div_by_zero <= 1'b0;
      exp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sgn <= a[7] ^ b[7];
          ea  <= a[6:3];
          eb  <= b[6:3];
          r   <= {2'b01, a[2:0]};
          d   <= {1'b1, b[2:0]};
          q   <= '0;
          cnt <= '0;
          if (b_zero) begin
            result      <= {a[7] ^ b[7], 7'h7F};
            div_by_zero <= 1'b1;
            exp_err     <= 1'b0;
          end else if (a_zero) begin
            result      <= {a[7] ^ b[7], 7'h00};
            div_by_zero <= 1'b0;
            exp_err     <= 1'b0;
          end
        end
        DIVIDE: begin
          q   <= {q[3:0], r_ge_d};
          r   <= r_sub << 1;
          cnt <= cnt + 3'd1;
        end
        NORM: begin
          result      <= {sgn, e[3:0], man};
          exp_err     <= e[5] | e[4];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float8_div_seq.sv
// Bench for float8_div_seq: directed vectors with a scoreboard queue.
// A negedge monitor pops the queue and compares each result as the consumer takes it.
module tb_float8_div_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, div_by_zero, exp_err;
  logic [7:0] a, b, result;

  typedef struct packed {
    logic [7:0] res;
    logic       dbz;
    logic       eerr;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  float8_div_seq #(.BIAS(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_by_zero(div_by_zero), .exp_err(exp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // The monitor compares a result whenever the consumer takes one.
  always @(negedge clk) begin
    exp_t got, ex;
    if (!rst && out_valid && out_ready) begin
      got = '{result, div_by_zero, exp_err};
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", got);
      end else begin
        ex = sb_q.pop_front();
        chk("result", {24'd0, got.res}, {24'd0, ex.res});
        chk("div_by_zero", {31'd0, got.dbz}, {31'd0, ex.dbz});
        chk("exp_err", {31'd0, got.eerr}, {31'd0, ex.eerr});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle", {31'd0, in_ready}, 32'd1);
  endtask

  // elat is the number of edges after the accept edge until out_valid rises.
  // Special operands reach DONE on the accept edge itself, so their elat is 0.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] er,
                       input logic edbz, input logic eerr, input int elat);
    int n;
    wait_idle();
    a = ta;
    b = tb;
    in_valid = 1'b1;
    sb_q.push_back('{er, edbz, eerr});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, elat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'h00);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_exp_err", {31'd0, exp_err}, 32'd0);
    rst = 1'b0;

    do_op(8'h38, 8'h38, 8'h38, 1'b0, 1'b0, 6);  // 1.0 / 1.0
    do_op(8'h38, 8'h44, 8'h2A, 1'b0, 1'b0, 6);  // 1/3, truncated to 0.3125
    do_op(8'hC4, 8'h40, 8'hBC, 1'b0, 1'b0, 6);  // -3.0 / 2.0 = -1.5
    do_op(8'h44, 8'h80, 8'hFF, 1'b1, 1'b0, 0);  // divide by -0
    do_op(8'h00, 8'h44, 8'h00, 1'b0, 1'b0, 0);  // zero dividend
    do_op(8'h80, 8'h44, 8'h80, 1'b0, 1'b0, 0);  // -0 / 3.0 keeps the sign
    do_op(8'h00, 8'h00, 8'h7F, 1'b1, 1'b0, 0);  // 0/0: divide by zero wins
    do_op(8'h78, 8'h08, 8'h28, 1'b0, 1'b1, 6);  // e=21 wraps to 5
    do_op(8'h08, 8'h78, 8'h48, 1'b0, 1'b1, 6);  // e=-7 wraps to 9

    // Backpressure: hold the result in DONE and offer new operands, which must be ignored.
    wait_idle();
    out_ready = 1'b0;
    do_op(8'h38, 8'h44, 8'h2A, 1'b0, 1'b0, 6);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a = 8'h44; b = 8'h38; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      chk("stall_result", {24'd0, result}, 32'h2A);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("no_capture_out_valid", {31'd0, out_valid}, 32'd0);
    chk("no_capture_in_ready", {31'd0, in_ready}, 32'd1);

    // Assert reset when count=2, then run a fresh operation.
    wait_idle();
    a = 8'h38; b = 8'h38; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", {24'd0, result}, 32'h00);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    do_op(8'hC4, 8'h40, 8'hBC, 1'b0, 1'b0, 6);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
